// File: rtl/retry_inorder_end.sv
// retry_inorder_end: closing stage of the in-order time-redundancy retry loop.
// Good elements are forwarded in order; a failed element triggers a retry request
// for its ID, and every element already in flight behind it is recirculated until
// the first re-issued element (resume ID) comes back.
// Optional macro RETRY_INORDER_END_STATS_EN adds a saturating 16-bit counter of
// accepted retry requests on retry_count_o; without it retry_count_o is tied to 0.
module retry_inorder_end #(
  parameter type DataType = logic,
  parameter int  IDSize   = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  DataType           data_i,
  input  logic [IDSize-1:0] id_i,
  input  logic              needs_retry_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [IDSize-1:0] retry_id_o,
  output logic              retry_valid_o,
  output logic              retry_lock_o,
  input  logic [IDSize-1:0] retry_id_i,
  input  logic              retry_ready_i,
  output logic [15:0]       retry_count_o
);

  typedef enum logic {
    PASS  = 1'b0,
    RETRY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDSize-1:0] resume_id_q, resume_id_d;

  logic id_match;
  logic fwd;
  logic fwd_hs;
  logic retry_hs;

  // Saturating increment for the retry statistics counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Payload and ID pass straight through; zero-cycle latency.
  assign data_o     = data_i;
  assign retry_id_o = id_i;

  // Classify the presented element: only the resume ID may leave RETRY, and only when good.
  always_comb begin
    id_match = (id_i == resume_id_q);
    fwd      = !needs_retry_i && ((state_q == PASS) || id_match);
  end

  // Handshakes: a forward never waits on the start stage, a retry never waits on the consumer.
  always_comb begin
    valid_o       = valid_i && fwd;
    retry_valid_o = valid_i && !fwd;
    ready_o       = fwd ? ready_i : retry_ready_i;
    fwd_hs        = valid_o && ready_i;
    retry_hs      = retry_valid_o && retry_ready_i;
  end

  // Lock upstream while recirculating, and already in the cycle a failure is first seen so
  // that anything the start stage issues alongside the request gets recirculated too.
  always_comb begin
    retry_lock_o = (state_q == RETRY) || (valid_i && needs_retry_i);
  end

  // Next-state logic: enter RETRY on an accepted retry, rearm the resume ID when the
  // resume element itself fails, leave RETRY when the resume element is forwarded.
  always_comb begin
    state_d     = state_q;
    resume_id_d = resume_id_q;
    unique case (state_q)
      PASS: begin
        if (retry_hs) begin
          state_d     = RETRY;
          resume_id_d = retry_id_i;
        end
      end
      RETRY: begin
        if (fwd_hs) begin
          state_d = PASS;
        end else if (retry_hs && id_match) begin
          resume_id_d = retry_id_i;
        end
      end
      default: begin
        state_d = PASS;
      end
    endcase
  end

  // State and resume-ID registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= PASS;
      resume_id_q <= '0;
    end else begin
      state_q     <= state_d;
      resume_id_q <= resume_id_d;
    end
  end

`ifdef RETRY_INORDER_END_STATS_EN
  logic [15:0] retry_count_q;

  // Count accepted retry requests, saturating at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retry_count_q <= 16'h0;
    end else if (retry_hs) begin
      retry_count_q <= sat_inc16(retry_count_q);
    end
  end

  assign retry_count_o = retry_count_q;
`else
  logic [15:0] unused_sat;

  // Statistics disabled: keep the saturation helper elaborated but drive a constant zero.
  always_comb begin
    unused_sat = sat_inc16(16'h0);
  end

  assign retry_count_o = unused_sat & 16'h0;
`endif

endmodule

// File: tb/tb_retry_inorder_end.sv
// Directed self-checking bench for retry_inorder_end (DataType = logic [7:0], IDSize = 3).
module tb_retry_inorder_end;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic [2:0] id_i;
  logic       needs_retry_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic [2:0] retry_id_o;
  logic       retry_valid_o;
  logic       retry_lock_o;
  logic [2:0] retry_id_i;
  logic       retry_ready_i;
  logic [15:0] retry_count_o;

  int n_cmp;
  int n_fail;

  // {valid_o, retry_valid_o, ready_o, retry_lock_o}
  logic [3:0] flags;
  assign flags = {valid_o, retry_valid_o, ready_o, retry_lock_o};

`ifdef RETRY_INORDER_END_STATS_EN
  localparam logic [15:0] CNT_BEFORE_RST = 16'd9;
`else
  localparam logic [15:0] CNT_BEFORE_RST = 16'd0;
`endif

  retry_inorder_end #(
    .DataType(logic [7:0]),
    .IDSize  (3)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_i       (data_i),
    .id_i         (id_i),
    .needs_retry_i(needs_retry_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .retry_id_o   (retry_id_o),
    .retry_valid_o(retry_valid_o),
    .retry_lock_o (retry_lock_o),
    .retry_id_i   (retry_id_i),
    .retry_ready_i(retry_ready_i),
    .retry_count_o(retry_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one set of inputs, then let them settle before sampling.
  task automatic drv(input logic v, input logic [2:0] id, input logic [7:0] d,
                     input logic nr, input logic rdy, input logic rrdy, input logic [2:0] rid);
    valid_i       = v;
    id_i          = id;
    data_i        = d;
    needs_retry_i = nr;
    ready_i       = rdy;
    retry_ready_i = rrdy;
    retry_id_i    = rid;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0);
    tick();
    n_cmp++;
    if ({valid_o, retry_valid_o, retry_lock_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000", {valid_o, retry_valid_o, retry_lock_o});
    end
    n_cmp++;
    if (retry_count_o !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d want 0", retry_count_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pass_forward();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 3'(i), 8'hA0 + 8'(i), 1'b0, 1'b1, 1'b1, 3'd3);
      n_cmp++;
      if (flags !== 4'b1010 || data_o !== 8'hA0 + 8'(i)) begin
        n_fail++;
        $display("FAIL pass_fwd_%0d: got flags %b data %h want flags 1010 data %h",
                 i, flags, data_o, 8'hA0 + 8'(i));
      end
      tick();
    end
  endtask

  task automatic test_retry_sequence();
    drv(1'b1, 3'd1, 8'hB1, 1'b1, 1'b1, 1'b1, 3'd4);
    n_cmp++;
    if (flags !== 4'b0111 || retry_id_o !== 3'd1) begin
      n_fail++;
      $display("FAIL retry_first: got flags %b id %0d want 0111 id 1", flags, retry_id_o);
    end
    tick();
    for (int i = 2; i < 4; i++) begin
      drv(1'b1, 3'(i), 8'hB0 + 8'(i), 1'b0, 1'b1, 1'b1, 3'd5);
      n_cmp++;
      if (flags !== 4'b0111 || retry_id_o !== 3'(i)) begin
        n_fail++;
        $display("FAIL recirc_%0d: got flags %b id %0d want 0111 id %0d", i, flags, retry_id_o, i);
      end
      tick();
    end
    drv(1'b1, 3'd4, 8'hC4, 1'b0, 1'b1, 1'b1, 3'd5);
    n_cmp++;
    if (flags !== 4'b1011 || data_o !== 8'hC4) begin
      n_fail++;
      $display("FAIL resume_fwd: got flags %b data %h want 1011 data c4", flags, data_o);
    end
    tick();
    drv(1'b0, 3'd5, 8'h00, 1'b0, 1'b1, 1'b1, 3'd5);
    n_cmp++;
    if (flags !== 4'b0010) begin
      n_fail++;
      $display("FAIL lock_release: got flags %b want 0010", flags);
    end
  endtask

  task automatic test_retry_stall();
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 3'd5, 8'hD5, 1'b1, 1'b1, 1'b0, 3'd6);
      n_cmp++;
      if (flags !== 4'b0101 || retry_id_o !== 3'd5) begin
        n_fail++;
        $display("FAIL retry_stall_%0d: got flags %b id %0d want 0101 id 5", i, flags, retry_id_o);
      end
      tick();
    end
    drv(1'b1, 3'd5, 8'hD5, 1'b1, 1'b1, 1'b1, 3'd6);
    n_cmp++;
    if (flags !== 4'b0111 || retry_id_o !== 3'd5) begin
      n_fail++;
      $display("FAIL retry_accept: got flags %b id %0d want 0111 id 5", flags, retry_id_o);
    end
    tick();
    drv(1'b1, 3'd6, 8'hD6, 1'b0, 1'b1, 1'b1, 3'd7);
    n_cmp++;
    if (flags !== 4'b1011) begin
      n_fail++;
      $display("FAIL stall_resume: got flags %b want 1011", flags);
    end
    tick();
  endtask

  task automatic test_retry_in_retry();
    drv(1'b1, 3'd3, 8'hE3, 1'b1, 1'b1, 1'b1, 3'd4);
    tick();
    drv(1'b1, 3'd4, 8'hE4, 1'b1, 1'b1, 1'b1, 3'd6);
    n_cmp++;
    if (flags !== 4'b0111 || retry_id_o !== 3'd4) begin
      n_fail++;
      $display("FAIL resume_fails: got flags %b id %0d want 0111 id 4", flags, retry_id_o);
    end
    tick();
    drv(1'b1, 3'd4, 8'hE4, 1'b0, 1'b1, 1'b1, 3'd7);
    n_cmp++;
    if (flags !== 4'b0111) begin
      n_fail++;
      $display("FAIL old_resume_recirc: got flags %b want 0111", flags);
    end
    tick();
    drv(1'b1, 3'd5, 8'hE5, 1'b0, 1'b1, 1'b1, 3'd7);
    n_cmp++;
    if (flags !== 4'b0111) begin
      n_fail++;
      $display("FAIL id5_recirc: got flags %b want 0111", flags);
    end
    tick();
    drv(1'b1, 3'd6, 8'hE6, 1'b0, 1'b1, 1'b1, 3'd7);
    n_cmp++;
    if (flags !== 4'b1011 || data_o !== 8'hE6) begin
      n_fail++;
      $display("FAIL new_resume_fwd: got flags %b data %h want 1011 data e6", flags, data_o);
    end
    tick();
    drv(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 3'd7);
    n_cmp++;
    if (flags !== 4'b0010) begin
      n_fail++;
      $display("FAIL back_in_pass: got flags %b want 0010", flags);
    end
  endtask

  task automatic test_stall_forward();
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, 3'd7, 8'h5A, 1'b0, 1'b0, 1'b1, 3'd0);
      n_cmp++;
      if (flags !== 4'b1000 || data_o !== 8'h5A) begin
        n_fail++;
        $display("FAIL fwd_stall_%0d: got flags %b data %h want 1000 data 5a", i, flags, data_o);
      end
      tick();
    end
    drv(1'b1, 3'd7, 8'h5A, 1'b0, 1'b1, 1'b1, 3'd0);
    tick();
    // Wrap-around: resume ID 0 after failing ID 7.
    drv(1'b1, 3'd7, 8'h5B, 1'b1, 1'b0, 1'b1, 3'd0);
    n_cmp++;
    if (flags !== 4'b0111 || retry_id_o !== 3'd7) begin
      n_fail++;
      $display("FAIL retry_no_ready: got flags %b id %0d want 0111 id 7", flags, retry_id_o);
    end
    tick();
  endtask

  task automatic test_reset_mid_retry();
    drv(1'b0, 3'd3, 8'h00, 1'b0, 1'b1, 1'b1, 3'd1);
    n_cmp++;
    if (flags !== 4'b0011) begin
      n_fail++;
      $display("FAIL in_retry_idle: got flags %b want 0011", flags);
    end
    n_cmp++;
    if (retry_count_o !== CNT_BEFORE_RST) begin
      n_fail++;
      $display("FAIL count_before_rst: got %0d want %0d", retry_count_o, CNT_BEFORE_RST);
    end
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (flags !== 4'b0010 || retry_count_o !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_mid_retry: got flags %b count %0d want 0010 count 0", flags, retry_count_o);
    end
    tick();
    rst_n = 1'b1;
    tick();
    drv(1'b1, 3'd2, 8'h77, 1'b0, 1'b1, 1'b1, 3'd3);
    n_cmp++;
    if (flags !== 4'b1010 || data_o !== 8'h77) begin
      n_fail++;
      $display("FAIL pass_after_rst: got flags %b data %h want 1010 data 77", flags, data_o);
    end
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    valid_i = 1'b0;
    id_i = '0;
    data_i = '0;
    needs_retry_i = 1'b0;
    ready_i = 1'b1;
    retry_ready_i = 1'b1;
    retry_id_i = '0;
    #1;
    test_reset();
    test_pass_forward();
    test_retry_sequence();
    test_retry_stall();
    test_retry_in_retry();
    test_stall_forward();
    test_reset_mid_retry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
